// File: rtl/iter_acc_pkg.sv
// rtl/iter_acc_pkg.sv - shared mode encoding and FSM state type for the iterative accumulator
package iter_acc_pkg;

    // Encoding 3 is reserved and treated like STOP by the step logic.
    typedef enum logic [1:0] {
        MODE_STOP = 2'd0,
        MODE_SAT  = 2'd1,
        MODE_WRAP = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/iter_acc_step.sv
// rtl/iter_acc_step.sv - one accumulate step: acc + b with the selected overflow policy
module iter_acc_step
    import iter_acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] b,
    input  mode_e            mode,
    output logic [WIDTH-1:0] acc_next,
    output logic             overflow
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, b};
        overflow = sum[WIDTH];
        acc_next = sum[WIDTH-1:0];
        if (sum[WIDTH]) begin
            case (mode)
                MODE_SAT:  acc_next = '1;
                MODE_WRAP: acc_next = sum[WIDTH-1:0];
                default:   acc_next = acc;
            endcase
        end
    end

endmodule

// File: rtl/iterative_accumulator.sv
// rtl/iterative_accumulator.sv - multi-cycle accumulator adding b to a loop_count times, one step per clock
module iterative_accumulator
    import iter_acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CNT_W-1:0] loop_count,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow_flag
);

    state_e           state;
    state_e           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] iter;
    mode_e            mode_q;
    logic             ovf;
    logic [WIDTH-1:0] step_acc;
    logic             step_ovf;
    logic             last_iter;

    iter_acc_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .b        (b_q),
        .mode     (mode_q),
        .acc_next (step_acc),
        .overflow (step_ovf)
    );

    assign last_iter = (iter == count_q);
    assign busy      = (state == ST_RUN);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)     state_next = ST_RUN;
            ST_RUN:  if (last_iter) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Inputs are captured only in IDLE, so a start while RUN is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            acc           <= '0;
            b_q           <= '0;
            count_q       <= '0;
            iter          <= '0;
            mode_q        <= MODE_STOP;
            ovf           <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            overflow_flag <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc     <= a;
                        b_q     <= b;
                        count_q <= loop_count;
                        mode_q  <= mode_e'(mode);
                        iter    <= '0;
                        ovf     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (last_iter) begin
                        result        <= acc;
                        overflow_flag <= ovf;
                        done          <= 1'b1;
                    end else begin
                        acc  <= step_acc;
                        ovf  <= ovf | step_ovf;
                        iter <= iter + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/iterative_accumulator.md
ITERATIVE_ACCUMULATOR -- requirements
Module: iterative_accumulator

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter CNT_W, default 3, width of loop_count (0 to 2^CNT_W-1 iterations).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request pulse; accepted only when busy=0.
REQ-006 a  input  WIDTH  initial accumulator value, sampled on accepted start.
REQ-007 b  input  WIDTH  addend, sampled on accepted start.
REQ-008 loop_count  input  CNT_W  number of additions, sampled on accepted start.
REQ-009 mode  input  2  overflow policy, sampled on accepted start: 0 STOP, 1 SAT, 2 WRAP, 3 reserved (acts as STOP).
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse; result/overflow_flag valid from this cycle.
REQ-012 result  output  WIDTH  final accumulator value; held until next done.
REQ-013 overflow_flag  output  1  high if any iteration of the last operation overflowed; held with result.

Function
REQ-014 FSM states IDLE and RUN only; IDLE->RUN on accepted start; RUN->IDLE on the edge where iteration count equals captured loop_count.
REQ-015 On accepted start: acc=a, iter=0, sticky ovf=0, operands/mode/loop_count captured; later input changes have no effect on the running operation.
REQ-016 Each RUN edge with iter<loop_count performs one step: sum=acc+b computed at WIDTH+1 bits; iter increments.
REQ-017 Step with sum<=2^WIDTH-1: acc=sum[WIDTH-1:0] in every mode.
REQ-018 Step with sum>2^WIDTH-1: ovf set; STOP keeps acc unchanged; SAT sets acc=2^WIDTH-1; WRAP sets acc=sum[WIDTH-1:0].
REQ-019 Overflow steps still consume an iteration; the operation never terminates early.
REQ-020 On the RUN->IDLE edge: result=acc, overflow_flag=ovf, done=1 for exactly one cycle, busy=0.
REQ-021 Latency: start accepted at edge k -> done high in the cycle following edge k+loop_count+1; loop_count=0 gives done after edge k+1 with result=a, overflow_flag=0.
REQ-022 busy=1 from the cycle after the accepting edge until the RUN->IDLE edge.
REQ-023 start while busy=1 is ignored, no queuing, no error indication.
REQ-024 start in the done cycle is accepted (back-to-back); done and result of the prior operation are unaffected.
REQ-025 result and overflow_flag change only on the RUN->IDLE edge or reset.

Reset
REQ-026 rst_n low: state=IDLE, busy=0, done=0, result=0, overflow_flag=0, internal acc/iter/ovf=0, immediately and without clock.
REQ-027 Reset during RUN aborts the operation; no done pulse is issued for it after release.
REQ-028 First start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package iter_acc_pkg holds the mode encoding (STOP/SAT/WRAP) and the FSM state type.
REQ-030 One combinational sub-module iter_acc_step (acc, b, mode -> next acc, overflow) implements REQ-017/018; the top holds FSM, counters and registers.
REQ-031 No combinational loop over loop_count; iteration is strictly one addition per clock.

Verification (WIDTH=8, CNT_W=3)
REQ-032 a=10,b=20,loop_count=3,mode=STOP -> done after 4 edges, result=70, overflow_flag=0.
REQ-033 a=200,b=30,loop_count=3,mode=STOP -> result=230, overflow_flag=1.
REQ-034 Same operands, mode=SAT -> result=255, overflow_flag=1; mode=WRAP -> result=34, overflow_flag=1.
REQ-035 a=0x5A,loop_count=0 -> done after 1 edge, result=0x5A; start asserted while busy in a 7-iteration run -> ignored, one done only.
REQ-036 rst_n pulsed low mid-run (loop_count=7) -> busy=0, result=0, no done; then start issued in a done cycle -> second operation completes with correct result.
